// File: rtl/acq_frame_frontend.sv
// Acquisition front end: XADC stream -> channel select, frame gating, optional
// boxcar decimation, frame markers and overrun tracking for the FFT/buffer path.
module acq_frame_frontend #(
  parameter int IN_W      = 16,
  parameter int ADC_BITS  = 12,
  parameter int OUT_W     = 16,
  parameter bit BIPOLAR   = 1'b1,
  parameter int FRAME_LEN = 1024,
  parameter int MAX_L2D   = 4
) (
  input  logic                           CLK,
  input  logic                           rstn,
  input  logic [IN_W-1:0]                s_tdata,
  input  logic                           s_tvalid,
  input  logic [4:0]                     s_tid,
  output logic                           s_tready,
  input  logic                           cfg_enable,
  input  logic [1:0]                     cfg_mode,
  input  logic [4:0]                     cfg_chan,
  input  logic [$clog2(MAX_L2D+1)-1:0]   cfg_l2d,
  input  logic                           arm,
  input  logic                           sink_full,
  input  logic                           ovr_clr,
  output logic [OUT_W-1:0]               m_data,
  output logic                           m_valid,
  output logic                           m_sof,
  output logic                           m_eof,
  output logic [15:0]                    frame_cnt,
  output logic                           busy,
  output logic                           overrun
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int ACC_W = OUT_W + MAX_L2D;
  localparam int L2W   = $clog2(MAX_L2D+1);
  localparam int DC_W  = (MAX_L2D > 0) ? MAX_L2D : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q;
  logic [4:0]         chan_q;
  logic [L2W-1:0]     l2d_q;
  logic [IDX_W-1:0]   idx_q;
  logic [ACC_W-1:0]   acc_q;
  logic [DC_W-1:0]    dcnt_q;
  logic               arm_q;
  logic [OUT_W-1:0]   m_data_q;
  logic               m_valid_q, m_sof_q, m_eof_q;
  logic [15:0]        frame_q;
  logic               ovr_q;

  logic               arm_rise, in_run, accept, qual, emit, last_idx, frame_end, start_frame;
  logic               decim, last_sum;
  logic [ADC_BITS-1:0] code;
  logic [ACC_W-1:0]   sample_ext, sum, shifted;
  logic [L2W-1:0]     eff_l2d;
  logic [DC_W-1:0]    dcnt_tgt;

  assign arm_rise = arm & ~arm_q;
  assign in_run   = (state_q == ST_RUN);
  // Outside RUN the stream is drained so stale samples never pile up upstream.
  assign s_tready = rstn & (~in_run | ~sink_full);
  assign accept   = s_tvalid & s_tready;
  assign qual     = accept & in_run & (s_tid == chan_q);

  assign code = s_tdata[IN_W-1 -: ADC_BITS];

  generate
    if (BIPOLAR) begin : g_signed
      assign sample_ext = {{(ACC_W-ADC_BITS){code[ADC_BITS-1]}}, code};
      assign shifted    = ACC_W'($signed(sum) >>> eff_l2d);
    end else begin : g_unsigned
      assign sample_ext = {{(ACC_W-ADC_BITS){1'b0}}, code};
      assign shifted    = sum >> eff_l2d;
    end
  endgenerate

  // Non-decimating modes behave as a decimation of 1, so one path covers all.
  assign decim     = (mode_q == 2'b10);
  assign eff_l2d   = decim ? l2d_q : '0;
  assign dcnt_tgt  = DC_W'((1 << eff_l2d) - 1);
  assign sum       = acc_q + sample_ext;
  assign last_sum  = (dcnt_q == dcnt_tgt);
  assign emit      = qual & last_sum;
  assign last_idx  = (idx_q == IDX_W'(FRAME_LEN-1));
  assign frame_end = emit & last_idx;

  wire unused_bits = ^{shifted[ACC_W-1:OUT_W], s_tdata[IN_W-ADC_BITS-1:0]};

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_enable & ~sink_full & ((cfg_mode != 2'b01) | arm_rise)) begin
          state_d     = ST_RUN;
          start_frame = 1'b1;
        end
      end
      ST_RUN: begin
        if (frame_end) begin
          if (mode_q == 2'b01) begin
            state_d = ST_DONE;
          end else if (~cfg_enable) begin
            state_d = ST_IDLE;
          end else begin
            start_frame = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (arm_rise & cfg_enable & ~sink_full) begin
          state_d     = ST_RUN;
          start_frame = 1'b1;
        end else if (~cfg_enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      mode_q    <= '0;
      chan_q    <= '0;
      l2d_q     <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      dcnt_q    <= '0;
      arm_q     <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_sof_q   <= 1'b0;
      m_eof_q   <= 1'b0;
      frame_q   <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm;
      // Configuration is frozen for the duration of a frame.
      if (start_frame) begin
        mode_q <= cfg_mode;
        chan_q <= cfg_chan;
        l2d_q  <= (cfg_l2d > L2W'(MAX_L2D)) ? L2W'(MAX_L2D) : cfg_l2d;
      end
      if (start_frame | emit) begin
        acc_q  <= '0;
        dcnt_q <= '0;
      end else if (qual) begin
        acc_q  <= sum;
        dcnt_q <= dcnt_q + DC_W'(1);
      end
      if (emit) begin
        idx_q    <= last_idx ? '0 : idx_q + IDX_W'(1);
        m_data_q <= shifted[OUT_W-1:0];
      end
      m_valid_q <= emit;
      m_sof_q   <= emit & (idx_q == '0);
      m_eof_q   <= frame_end;
      frame_q   <= frame_q + {15'd0, frame_end};
      // A lost sample in the same cycle as a clear must remain visible.
      if (in_run & s_tvalid & ~s_tready) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_sof     = m_sof_q;
  assign m_eof     = m_eof_q;
  assign frame_cnt = frame_q;
  assign busy      = in_run;
  assign overrun   = ovr_q;

endmodule
